// File: rtl/aes_out_serializer_pkg.sv
// Shared AES datapath constants for the output serializer.
//   BLK_S         : AES block width in bits
//   WORD_S        : AXI4-Stream data width in bits
//   WORDS_PER_BLK : output words per block (derived)
// Helper functions compute the same values for non-default parameterisations.
package aes_out_serializer_pkg;

   localparam int BLK_S         = 128;
   localparam int WORD_S        = 32;
   localparam int WORDS_PER_BLK = BLK_S / WORD_S;

   function automatic int words_per_blk(input int blk_s, input int word_s);
      return blk_s / word_s;
   endfunction

   // A one-word block still needs a 1-bit index register.
   function automatic int idx_width(input int n_words);
      return (n_words > 1) ? $clog2(n_words) : 1;
   endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Two-entry FIFO of {last, block} between the AES controller and the
// output serializer. Entry 0 is always the head.
// Ports:
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : {in_last, in_blk}
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : head entry contents
//   empty_o       : no entries held
//   full_o        : two entries held
module aes_blk_fifo #(
   parameter int DW = 129
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push_i,
   input  logic [DW-1:0] push_data_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_o,
   output logic          empty_o,
   output logic          full_o
);

   logic [1:0]    cnt_q, cnt_d;
   logic [DW-1:0] e0_q, e0_d;
   logic [DW-1:0] e1_q, e1_d;
   logic          push_ok, pop_ok;

   always_comb begin
      push_ok = push_i && (cnt_q != 2'd2);
      pop_ok  = pop_i && (cnt_q != 2'd0);
      cnt_d   = cnt_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      if (push_ok && pop_ok) begin
         // Only possible with exactly one entry: the new block becomes head.
         e0_d = push_data_i;
      end else if (pop_ok) begin
         e0_d  = e1_q;
         cnt_d = cnt_q - 2'd1;
      end else if (push_ok) begin
         if (cnt_q == 2'd0) begin
            e0_d = push_data_i;
         end else begin
            e1_d = push_data_i;
         end
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
      end
   end

   assign head_o  = e0_q;
   assign empty_o = (cnt_q == 2'd0);
   assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/aes_out_serializer.sv
// Serializes processed AES blocks onto an AXI4-Stream master, most
// significant word first, with a two-block input buffer.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits for ready, and data/last hold while
// valid && !ready.
// Ports:
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   in_blk, in_last  : block from the AES controller and its end-of-request flag
//   in_valid/in_ready: input handshake (ready = fewer than two blocks held)
//   m00_axis_*       : output stream (tdata, tvalid, tready, tlast)
//   blk_count        : blocks fully emitted since reset (wraps)
module aes_out_serializer #(
   parameter int BLK_S  = aes_out_serializer_pkg::BLK_S,
   parameter int WORD_S = aes_out_serializer_pkg::WORD_S
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [BLK_S-1:0]  in_blk,
   input  logic              in_last,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_S-1:0] m00_axis_tdata,
   output logic              m00_axis_tvalid,
   input  logic              m00_axis_tready,
   output logic              m00_axis_tlast,
   output logic [31:0]       blk_count
);

   import aes_out_serializer_pkg::*;

   localparam int WPB   = words_per_blk(BLK_S, WORD_S);
   localparam int IDX_W = idx_width(WPB);

   logic [BLK_S:0]   head;
   logic             fifo_empty, fifo_full;
   logic             push, pop, hs, last_word;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      blk_cnt_q, blk_cnt_d;

   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;

   aes_blk_fifo #(.DW(BLK_S + 1)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push_i      (push),
      .push_data_i ({in_last, in_blk}),
      .pop_i       (pop),
      .head_o      (head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full)
   );

   assign m00_axis_tvalid = !fifo_empty;
   assign hs              = m00_axis_tvalid && m00_axis_tready;
   assign last_word       = (idx_q == IDX_W'(WPB - 1));
   assign pop             = hs && last_word;
   assign m00_axis_tlast  = !fifo_empty && last_word && head[BLK_S];

   always_comb begin
      idx_d     = idx_q;
      blk_cnt_d = blk_cnt_q;
      if (hs) begin
         idx_d = last_word ? '0 : idx_q + IDX_W'(1);
      end
      if (pop) begin
         blk_cnt_d = blk_cnt_q + 32'd1;
      end
   end

   // Word k of the head block, most significant word first.
   always_comb begin
      m00_axis_tdata = '0;
      for (int k = 0; k < WPB; k++) begin
         if (idx_q == IDX_W'(k)) begin
            m00_axis_tdata = head[BLK_S-1-k*WORD_S -: WORD_S];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx_q     <= '0;
         blk_cnt_q <= 32'd0;
      end else begin
         idx_q     <= idx_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign blk_count = blk_cnt_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
module tb_aes_out_serializer;

   localparam int BLK_S  = 128;
   localparam int WORD_S = 32;
   localparam int WPB    = 4;

   localparam logic [BLK_S-1:0] B0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [BLK_S-1:0] B1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
   localparam logic [BLK_S-1:0] B2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FEEDFACE;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [BLK_S-1:0]  in_blk = '0;
   logic              in_last = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WORD_S-1:0] m00_axis_tdata;
   logic              m00_axis_tvalid;
   logic              m00_axis_tready = 1'b0;
   logic              m00_axis_tlast;
   logic [31:0]       blk_count;

   aes_out_serializer #(.BLK_S(BLK_S), .WORD_S(WORD_S)) dut (
      .clock           (clock),
      .reset           (reset),
      .in_blk          (in_blk),
      .in_last         (in_last),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .m00_axis_tdata  (m00_axis_tdata),
      .m00_axis_tvalid (m00_axis_tvalid),
      .m00_axis_tready (m00_axis_tready),
      .m00_axis_tlast  (m00_axis_tlast),
      .blk_count       (blk_count)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // scoreboard: {tlast, tdata}
   logic [WORD_S:0] exp_q[$];
   logic [WORD_S:0] got_q[$];
   int              gotc_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // monitor: occupancy model, stall stability, output capture
   int              m_occ = 0;
   int              m_widx = 0;
   logic            prev_stall = 1'b0;
   logic [WORD_S:0] prev_word = '0;

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            m_occ      = 0;
            m_widx     = 0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_tvalid", 64'(m00_axis_tvalid), 64'd1);
               check("hold_word", 64'({m00_axis_tlast, m00_axis_tdata}), 64'(prev_word));
            end
            check("in_ready_occ", 64'(in_ready), 64'(m_occ < 2));
            check("tvalid_occ", 64'(m00_axis_tvalid), 64'(m_occ > 0));
            if (m00_axis_tvalid && m00_axis_tready) begin
               got_q.push_back({m00_axis_tlast, m00_axis_tdata});
               gotc_q.push_back(cyc);
               if (m_widx == WPB - 1) begin
                  m_widx = 0;
                  m_occ--;
               end else begin
                  m_widx++;
               end
            end
            if (in_valid && in_ready) m_occ++;
            prev_stall = m00_axis_tvalid && !m00_axis_tready;
            prev_word  = {m00_axis_tlast, m00_axis_tdata};
         end
      end
   end

   // driver tasks (called at posedge + 1)
   task automatic push_blk(input logic [BLK_S-1:0] b, input logic l);
      int n;
      n        = 0;
      in_blk   = b;
      in_last  = l;
      in_valid = 1'b1;
      @(negedge clock);
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (n >= 200) check("push_timeout", 64'd0, 64'd1);
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic expect_blk(input logic [BLK_S-1:0] b, input logic l);
      for (int k = 0; k < WPB; k++) begin
         exp_q.push_back({l && (k == WPB - 1), b[BLK_S-1-k*WORD_S -: WORD_S]});
      end
   endtask

   task automatic wait_words(input int n);
      int c;
      c = 0;
      while (got_q.size() < n && c < 300) begin
         @(negedge clock);
         c++;
      end
      if (got_q.size() < n) check("wait_words_timeout", 64'(got_q.size()), 64'(n));
      @(posedge clock);
      #1;
   endtask

   task automatic compare_sb(input string tag);
      wait_words(exp_q.size());
      repeat (3) @(negedge clock);
      while (exp_q.size() > 0) begin
         if (got_q.size() == 0) begin
            check({tag, "_missing"}, 64'd0, 64'(exp_q.pop_front()));
         end else begin
            check(tag, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
            void'(gotc_q.pop_front());
         end
      end
      check({tag, "_extra"}, 64'(got_q.size()), 64'd0);
      got_q.delete();
      gotc_q.delete();
      @(posedge clock);
      #1;
   endtask

   logic [WORD_S-1:0] t1_w[WPB];
   int                n_last;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      t1_w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

      // reset state
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_tvalid", 64'(m00_axis_tvalid), 64'd0);
      check("rst_tlast", 64'(m00_axis_tlast), 64'd0);
      check("rst_tdata", 64'(m00_axis_tdata), 64'd0);
      check("rst_blk_count", 64'(blk_count), 64'd0);
      @(posedge clock);
      #1;

      // single block, 1-cycle latency, tlast on final word only
      m00_axis_tready = 1'b1;
      push_blk(B0, 1'b1);
      for (int k = 0; k < WPB; k++) begin
         @(negedge clock);
         check("t1_tvalid", 64'(m00_axis_tvalid), 64'd1);
         check("t1_tdata", 64'(m00_axis_tdata), 64'(t1_w[k]));
         check("t1_tlast", 64'(m00_axis_tlast), 64'(k == WPB - 1));
      end
      @(negedge clock);
      check("t1_tvalid_after", 64'(m00_axis_tvalid), 64'd0);
      check("t1_blk_count", 64'(blk_count), 64'd1);
      @(posedge clock);
      #1;
      expect_blk(B0, 1'b1);
      compare_sb("t1_sb");

      // three back-to-back blocks, no bubbles
      expect_blk(B0, 1'b0);
      expect_blk(B1, 1'b0);
      expect_blk(B2, 1'b1);
      push_blk(B0, 1'b0);
      push_blk(B1, 1'b0);
      push_blk(B2, 1'b1);
      wait_words(12);
      for (int i = 1; i < 12 && i < gotc_q.size(); i++) begin
         check("t2_gap", 64'(gotc_q[i] - gotc_q[0]), 64'(i));
      end
      n_last = 0;
      foreach (got_q[i]) if (got_q[i][WORD_S]) n_last++;
      check("t2_tlast_cnt", 64'(n_last), 64'd1);
      if (got_q.size() >= 12) check("t2_tlast_pos", 64'(got_q[11][WORD_S]), 64'd1);
      compare_sb("t2_sb");
      check("t2_blk_count", 64'(blk_count), 64'd4);

      // tready 1 high / 8 low
      m00_axis_tready = 1'b0;
      expect_blk(B1, 1'b0);
      expect_blk(B2, 1'b1);
      push_blk(B1, 1'b0);
      push_blk(B2, 1'b1);
      for (int c = 0; c < 300 && got_q.size() < 8; c++) begin
         m00_axis_tready = (c % 9 == 0);
         @(posedge clock);
         #1;
      end
      m00_axis_tready = 1'b1;
      compare_sb("t3_sb");

      // two blocks held with tready low, in_ready returns after 4th handshake
      m00_axis_tready = 1'b0;
      expect_blk(B2, 1'b0);
      expect_blk(B0, 1'b1);
      push_blk(B2, 1'b0);
      push_blk(B0, 1'b1);
      @(negedge clock);
      check("t4_full", 64'(in_ready), 64'd0);
      @(posedge clock);
      #1 m00_axis_tready = 1'b1;
      for (int k = 0; k < WPB; k++) begin
         @(negedge clock);
         check("t4_ready_low", 64'(in_ready), 64'd0);
      end
      @(negedge clock);
      check("t4_ready_back", 64'(in_ready), 64'd1);
      @(posedge clock);
      #1;
      compare_sb("t4_sb");

      // reset after the 2nd word discards the rest of the block
      push_blk(B1, 1'b1);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("t5_tvalid", 64'(m00_axis_tvalid), 64'd0);
      check("t5_in_ready", 64'(in_ready), 64'd1);
      check("t5_blk_count", 64'(blk_count), 64'd0);
      check("t5_tlast", 64'(m00_axis_tlast), 64'd0);
      check("t5_tdata", 64'(m00_axis_tdata), 64'd0);
      @(posedge clock);
      #1;
      exp_q.push_back({1'b0, 32'h01234567});
      exp_q.push_back({1'b0, 32'h89ABCDEF});
      compare_sb("t5_partial");
      expect_blk(B2, 1'b1);
      push_blk(B2, 1'b1);
      compare_sb("t5_new");
      check("t5_blk_count_new", 64'(blk_count), 64'd1);

      // blk_count wrap
      dut.blk_cnt_q = 32'hFFFF_FFFE;
      @(negedge clock);
      check("t6_preload", 64'(blk_count), 64'hFFFF_FFFE);
      @(posedge clock);
      #1;
      expect_blk(B0, 1'b0);
      expect_blk(B1, 1'b1);
      push_blk(B0, 1'b0);
      push_blk(B1, 1'b1);
      wait_words(4);
      @(negedge clock);
      check("t6_blk_count_mid", 64'(blk_count), 64'hFFFF_FFFF);
      @(posedge clock);
      #1;
      compare_sb("t6_sb");
      check("t6_blk_count_wrap", 64'(blk_count), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
